// File: rtl/latch_sync_multi_if.sv
// -----------------------------------------------------------------------------
// latch_sync_multi_if
// Bundle between the SAR sequencers / display latch registers and the
// multi-channel output-latch synchroniser.
//
//   conv_clk    [CHANNELS]  per-channel conversion clock (asynchronous)
//   eoc         [CHANNELS]  per-channel end of conversion (asynchronous)
//   hold_cycles [CNT_W]     hold length shared by all channels
//   retrig                  1 = conv_clk edge during HOLD reloads the counter
//   clr_timeout [CHANNELS]  synchronous clear of the sticky timeout flags
//   out         [CHANNELS]  registered latch window
//   load        [CHANNELS]  one-cycle strobe on every counter (re)load
//   timeout     [CHANNELS]  sticky flag: WAIT expired without conv_clk edge
//
// master: the side that drives the converter inputs and configuration.
// slave : the synchroniser itself.
// -----------------------------------------------------------------------------
interface latch_sync_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 21
);
    logic [CHANNELS-1:0] conv_clk;
    logic [CHANNELS-1:0] eoc;
    logic [CNT_W-1:0]    hold_cycles;
    logic                retrig;
    logic [CHANNELS-1:0] clr_timeout;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] timeout;

    modport master (
        output conv_clk,
        output eoc,
        output hold_cycles,
        output retrig,
        output clr_timeout,
        input  out,
        input  load,
        input  timeout
    );

    modport slave (
        input  conv_clk,
        input  eoc,
        input  hold_cycles,
        input  retrig,
        input  clr_timeout,
        output out,
        output load,
        output timeout
    );
endinterface

// File: rtl/latch_sync_multi.sv
// -----------------------------------------------------------------------------
// latch_sync_multi
// Multi-channel SAR output-latch synchroniser in the clk50 domain. Each
// channel synchronises its asynchronous eoc / conv_clk inputs, detects rising
// edges and runs a three-state window FSM:
//   IDLE -> (eoc edge) -> WAIT -> (conv_clk edge) -> HOLD -> (count done) -> IDLE
// out is high in WAIT and HOLD. HOLD lasts hold_cycles clk50 cycles after the
// loading edge. An optional WAIT timeout returns to IDLE and sets a sticky flag.
//
// Ports:
//   clk50   system clock, all state on its rising edge
//   rst_n   asynchronous active-low reset
//   bus     latch_sync_multi_if.slave (see interface header for signals)
//
// Parameters:
//   CHANNELS      number of independent channels
//   CNT_W         width of the hold and wait counters
//   SYNC_STAGES   synchroniser depth per async input (2 or more)
//   WAIT_TIMEOUT  max clk50 cycles spent in WAIT, 0 disables the timeout
// -----------------------------------------------------------------------------
module latch_sync_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 21,
    parameter int SYNC_STAGES  = 2,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic                  clk50,
    input  logic                  rst_n,
    latch_sync_multi_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam bit              TMO_EN   = (WAIT_TIMEOUT > 0);
    // The wait counter reads N-1 during the N-th cycle spent in WAIT, so the
    // exit edge lands exactly WAIT_TIMEOUT cycles after WAIT entry.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);

    logic hold_zero_s;
    assign hold_zero_s = (bus.hold_cycles == {CNT_W{1'b0}});

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

        // Synchroniser chains; the last stage is the synchronised level and
        // prev holds its value from the previous cycle.
        logic [SYNC_STAGES-1:0] cc_sync_q;
        logic [SYNC_STAGES-1:0] eoc_sync_q;
        logic                   cc_prev_q;
        logic                   eoc_prev_q;
        logic                   cc_edge_s;
        logic                   eoc_edge_s;
        logic                   tmo_hit_s;

        state_e                 state_q;
        state_e                 state_d;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic [CNT_W-1:0]       wcnt_q;
        logic [CNT_W-1:0]       wcnt_d;
        logic                   out_q;
        logic                   out_d;
        logic                   load_q;
        logic                   load_d;
        logic                   tmo_q;
        logic                   tmo_d;

        // Synchronise both async inputs; reset to 1 so an input that is
        // already high at reset release never looks like a rising edge.
        always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
                cc_sync_q  <= {SYNC_STAGES{1'b1}};
                eoc_sync_q <= {SYNC_STAGES{1'b1}};
                cc_prev_q  <= 1'b1;
                eoc_prev_q <= 1'b1;
            end else begin
                cc_sync_q  <= {cc_sync_q[SYNC_STAGES-2:0], bus.conv_clk[g]};
                eoc_sync_q <= {eoc_sync_q[SYNC_STAGES-2:0], bus.eoc[g]};
                cc_prev_q  <= cc_sync_q[SYNC_STAGES-1];
                eoc_prev_q <= eoc_sync_q[SYNC_STAGES-1];
            end
        end

        assign cc_edge_s  = cc_sync_q[SYNC_STAGES-1]  & ~cc_prev_q;
        assign eoc_edge_s = eoc_sync_q[SYNC_STAGES-1] & ~eoc_prev_q;
        assign tmo_hit_s  = TMO_EN && (wcnt_q == TMO_LAST);

        // Window FSM next-state, counter and output decode.
        always_comb begin
            logic tmo_set_v;
            state_d   = state_q;
            cnt_d     = cnt_q;
            wcnt_d    = wcnt_q;
            out_d     = out_q;
            load_d    = 1'b0;
            tmo_set_v = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A conv_clk edge arriving together with eoc is consumed.
                    if (eoc_edge_s) begin
                        state_d = ST_WAIT;
                        wcnt_d  = {CNT_W{1'b0}};
                        out_d   = 1'b1;
                    end else begin
                        out_d   = 1'b0;
                    end
                end

                ST_WAIT: begin
                    // The conv_clk edge is checked first so it beats expiry.
                    if (cc_edge_s) begin
                        load_d = 1'b1;
                        cnt_d  = bus.hold_cycles;
                        if (hold_zero_s) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b0;
                        end else begin
                            state_d = ST_HOLD;
                            out_d   = 1'b1;
                        end
                    end else if (tmo_hit_s) begin
                        state_d   = ST_IDLE;
                        out_d     = 1'b0;
                        tmo_set_v = 1'b1;
                    end else begin
                        wcnt_d    = wcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        out_d     = 1'b1;
                    end
                end

                ST_HOLD: begin
                    // Reload takes priority over the final count cycle.
                    if (bus.retrig && cc_edge_s) begin
                        load_d = 1'b1;
                        cnt_d  = bus.hold_cycles;
                        if (hold_zero_s) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b0;
                        end else begin
                            state_d = ST_HOLD;
                            out_d   = 1'b1;
                        end
                    end else if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                        out_d   = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        out_d   = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    wcnt_d  = {CNT_W{1'b0}};
                    out_d   = 1'b0;
                end
            endcase

            // Sticky flag: a new timeout beats a simultaneous clear.
            if (tmo_set_v) begin
                tmo_d = 1'b1;
            end else if (bus.clr_timeout[g]) begin
                tmo_d = 1'b0;
            end else begin
                tmo_d = tmo_q;
            end
        end

        // Window FSM state, counters and registered outputs.
        always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= {CNT_W{1'b0}};
                wcnt_q  <= {CNT_W{1'b0}};
                out_q   <= 1'b0;
                load_q  <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wcnt_q  <= wcnt_d;
                out_q   <= out_d;
                load_q  <= load_d;
                tmo_q   <= tmo_d;
            end
        end

        assign bus.out[g]     = out_q;
        assign bus.load[g]    = load_q;
        assign bus.timeout[g] = tmo_q;
    end

endmodule
